// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Circular FIFO of committed stores waiting to be written into the dcache.
//   A drain FSM probes the dcache with the head entry, backs off for RETRY_GAP
//   idle cycles on a miss and writes the head once the probe hits. Loads look
//   up the buffer combinationally and either receive forwarded data or are
//   told to replay when only a partial (byte) overlap is buffered.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   enq_en/isbyte/addr/data        committed store entering the tail
//   full, empty                    occupancy flags
//   probe_en, probe_addr           head lookup request to the dcache
//   probe_miss                     dcache response, one cycle after probe_en
//   store_en/isbyte/addr/data      head write into the dcache (one cycle)
//   ld_addr, ld_isbyte             load lookup
//   fwd_hit, fwd_data              forwarded load data
//   fwd_conflict                   load overlaps a buffered byte and must replay
//
// Byte stores carry their byte in data[7:0]; addr[1:0] selects the lane.
// Forwarding matches on addr[31:2] (tag, index and word offset).
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int RETRY_GAP = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enq_en,
    input  logic        enq_isbyte,
    input  logic [31:0] enq_addr,
    input  logic [31:0] enq_data,
    output logic        full,
    output logic        empty,
    output logic        probe_en,
    output logic [31:0] probe_addr,
    input  logic        probe_miss,
    output logic        store_en,
    output logic        store_isbyte,
    output logic [31:0] store_addr,
    output logic [31:0] store_data,
    input  logic [31:0] ld_addr,
    input  logic        ld_isbyte,
    output logic        fwd_hit,
    output logic [31:0] fwd_data,
    output logic        fwd_conflict
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(RETRY_GAP);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROBE   = 3'd1,
        ST_RESP    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    // Lane extraction for byte loads that hit a buffered word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] lane;
        case (off)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            2'd3:    lane = word[31:24];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] isbyte_r;
    logic [31:0]      addr_r [DEPTH];
    logic [31:0]      data_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    state_t           state_r;
    state_t           state_next_s;
    logic [GW-1:0]    gap_r;
    logic [GW-1:0]    gap_next_s;

    logic             probe_en_r;
    logic [31:0]      probe_addr_r;
    logic             store_en_r;
    logic             store_isbyte_r;
    logic [31:0]      store_addr_r;
    logic [31:0]      store_data_r;

    logic             push_s;
    logic             pop_s;

    logic [PW-1:0]    age_idx_s [DEPTH];
    logic [DEPTH-1:0] age_match_s;
    logic             fwd_found_s;
    logic [PW-1:0]    fwd_sel_s;
    logic             fwd_hit_s;
    logic             fwd_conflict_s;
    logic [31:0]      fwd_data_s;

    // Full is taken from the current count only, so a pop in the same cycle
    // does not open a slot for an enqueue that arrives while full.
    assign full   = (count_r == CNT_FULL);
    assign empty  = (count_r == '0);
    assign push_s = enq_en & ~full;
    assign pop_s  = (state_r == ST_COMMIT);

    // Head/tail pointers, occupancy count and valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            valid_r <= '0;
        end else begin
            if (push_s) begin
                tail_r          <= tail_r + PTR_ONE;
                valid_r[tail_r] <= 1'b1;
            end
            if (pop_s) begin
                head_r          <= head_r + PTR_ONE;
                valid_r[head_r] <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; only the tail slot is ever written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isbyte_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
                data_r[i] <= '0;
            end
        end else if (push_s) begin
            isbyte_r[tail_r] <= enq_isbyte;
            addr_r[tail_r]   <= enq_addr;
            data_r[tail_r]   <= enq_data;
        end
    end

    // Drain FSM next-state and backoff counter.
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty) begin
                    state_next_s = ST_PROBE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PROBE: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (probe_miss) begin
                    state_next_s = ST_BACKOFF;
                    gap_next_s   = GAP_LOAD;
                end else begin
                    state_next_s = ST_COMMIT;
                    gap_next_s   = gap_r;
                end
            end
            ST_BACKOFF: begin
                // The last backoff cycle is the one in which the counter
                // reaches zero, giving exactly RETRY_GAP idle cycles.
                if (gap_r <= GAP_ONE) begin
                    state_next_s = ST_PROBE;
                    gap_next_s   = '0;
                end else begin
                    state_next_s = ST_BACKOFF;
                    gap_next_s   = gap_r - GAP_ONE;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                gap_next_s   = '0;
            end
        endcase
    end

    // Drain FSM state and backoff counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            gap_r   <= '0;
        end else begin
            state_r <= state_next_s;
            gap_r   <= gap_next_s;
        end
    end

    // Registered dcache request outputs, loaded for the state being entered.
    // The head cannot move outside IDLE, so sampling it here is stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            probe_en_r     <= 1'b0;
            probe_addr_r   <= '0;
            store_en_r     <= 1'b0;
            store_isbyte_r <= 1'b0;
            store_addr_r   <= '0;
            store_data_r   <= '0;
        end else begin
            probe_en_r     <= (state_next_s == ST_PROBE);
            probe_addr_r   <= (state_next_s == ST_PROBE)  ? addr_r[head_r] : '0;
            store_en_r     <= (state_next_s == ST_COMMIT);
            store_isbyte_r <= (state_next_s == ST_COMMIT) ? isbyte_r[head_r] : 1'b0;
            store_addr_r   <= (state_next_s == ST_COMMIT) ? addr_r[head_r] : '0;
            store_data_r   <= (state_next_s == ST_COMMIT) ? data_r[head_r] : '0;
        end
    end

    assign probe_en     = probe_en_r;
    assign probe_addr   = probe_addr_r;
    assign store_en     = store_en_r;
    assign store_isbyte = store_isbyte_r;
    assign store_addr   = store_addr_r;
    assign store_data   = store_data_r;

    // Per-age lookup: age 0 is the entry just behind tail (youngest).
    always_comb begin
        age_match_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            age_idx_s[k]   = tail_r - PTR_ONE - PW'(k);
            age_match_s[k] = valid_r[age_idx_s[k]] &&
                             (addr_r[age_idx_s[k]][31:2] == ld_addr[31:2]);
        end
    end

    // Youngest-match select: visiting oldest first lets the youngest win.
    always_comb begin
        fwd_found_s = 1'b0;
        fwd_sel_s   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            fwd_found_s = age_match_s[k] ? 1'b1 : fwd_found_s;
            fwd_sel_s   = age_match_s[k] ? age_idx_s[k] : fwd_sel_s;
        end
    end

    // Forwarding decision on the youngest matching entry.
    always_comb begin
        fwd_hit_s      = 1'b0;
        fwd_conflict_s = 1'b0;
        fwd_data_s     = '0;
        if (!fwd_found_s) begin
            fwd_hit_s      = 1'b0;
            fwd_conflict_s = 1'b0;
        end else if (!isbyte_r[fwd_sel_s]) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = ld_isbyte ? {24'h000000, byte_lane(data_r[fwd_sel_s], ld_addr[1:0])}
                                   : data_r[fwd_sel_s];
        end else if (ld_isbyte && (addr_r[fwd_sel_s][1:0] == ld_addr[1:0])) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = {24'h000000, data_r[fwd_sel_s][7:0]};
        end else begin
            // Only part of the requested data is buffered: the load replays.
            fwd_conflict_s = 1'b1;
        end
    end

    assign fwd_hit      = fwd_hit_s;
    assign fwd_conflict = fwd_conflict_s;
    assign fwd_data     = fwd_data_s;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Directed scenarios for store_buffer (DEPTH=4, RETRY_GAP=3). Accepted
//   enqueues are pushed to a scoreboard queue; a monitor pops and compares
//   every store_en against it. A small dcache responder drives probe_miss one
//   cycle after each probe_en from a miss budget or a hold flag.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_en;
    logic        enq_isbyte;
    logic [31:0] enq_addr;
    logic [31:0] enq_data;
    logic        full;
    logic        empty;
    logic        probe_en;
    logic [31:0] probe_addr;
    logic        probe_miss;
    logic        store_en;
    logic        store_isbyte;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic [31:0] ld_addr;
    logic        ld_isbyte;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_conflict;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          miss_hold   = 1'b0;
    int          miss_budget = 0;
    logic        prev_probe  = 1'b0;
    logic [64:0] sb [$];
    logic [64:0] mon_exp;

    store_buffer #(.DEPTH(4), .RETRY_GAP(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_en      (enq_en),
        .enq_isbyte  (enq_isbyte),
        .enq_addr    (enq_addr),
        .enq_data    (enq_data),
        .full        (full),
        .empty       (empty),
        .probe_en    (probe_en),
        .probe_addr  (probe_addr),
        .probe_miss  (probe_miss),
        .store_en    (store_en),
        .store_isbyte(store_isbyte),
        .store_addr  (store_addr),
        .store_data  (store_data),
        .ld_addr     (ld_addr),
        .ld_isbyte   (ld_isbyte),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .fwd_conflict(fwd_conflict)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every dcache write must be the oldest accepted store.
    always @(posedge clk) begin
        #1;
        if (store_en === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_store got addr=%h data=%h want no store", store_addr, store_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({store_isbyte, store_addr, store_data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL store_order got %b/%h/%h want %b/%h/%h", store_isbyte, store_addr,
                             store_data, mon_exp[64], mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    // One clock step; also plays the dcache, answering the previous cycle's probe.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        probe_miss = prev_probe && (miss_hold || (miss_budget > 0));
        if (prev_probe && !miss_hold && (miss_budget > 0)) miss_budget--;
        prev_probe = probe_en;
    endtask

    task automatic enq(input logic isb, input logic [31:0] a, input logic [31:0] d, input bit accept);
        enq_en     = 1'b1;
        enq_isbyte = isb;
        enq_addr   = a;
        enq_data   = d;
        if (accept) sb.push_back({isb, a, d});
        tick();
        enq_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enq_en = 1'b0; enq_isbyte = 1'b0; enq_addr = '0; enq_data = '0;
        probe_miss = 1'b0; ld_addr = 32'h0000_0000; ld_isbyte = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({full, empty, probe_en, store_en, fwd_hit, fwd_conflict} !== 6'b010000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 010000", {full, empty, probe_en, store_en, fwd_hit, fwd_conflict});
        end
        vectors++;
        if ({probe_addr, store_addr, store_data, fwd_data} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h/%h/%h want zeros", probe_addr, store_addr, store_data, fwd_data);
        end
        rst = 1'b1;
    endtask

    task automatic test_full_drop();
        int n;
        miss_hold = 1'b1;
        for (int i = 0; i < 4; i++) enq(1'b0, 32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
        vectors++;
        if ({full, empty} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_after_4 got %b want 10", {full, empty});
        end
        enq(1'b0, 32'h0000_0200, 32'hBAD0_BAD0, 1'b0);
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after_drop got %b want 1", full);
        end
        miss_hold = 1'b0;
        n = 0;
        while (empty !== 1'b1 && n < 80) begin tick(); n++; end
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drain_timeout got empty=%b want 1", empty);
        end
        repeat (6) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_drain_left got %0d want 0", sb.size());
        end
    endtask

    task automatic test_single_store();
        enq(1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
        vectors++;
        if ({empty, probe_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_c0 got %b want 00", {empty, probe_en});
        end
        tick();
        vectors++;
        if ({probe_en, probe_addr} !== {1'b1, 32'h0000_1004}) begin
            miscompares++;
            $display("FAIL single_probe got %b/%h want 1/00001004", probe_en, probe_addr);
        end
        tick();
        vectors++;
        if ({probe_en, store_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL single_resp got %b want 00", {probe_en, store_en});
        end
        tick();
        vectors++;
        if ({store_en, store_isbyte, store_addr, store_data} !== {2'b10, 32'h0000_1004, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL single_commit got %b/%h/%h want 1/00001004/deadbeef", store_en, store_addr, store_data);
        end
        tick();
        vectors++;
        if ({empty, store_en} !== 2'b10) begin
            miscompares++;
            $display("FAIL single_empty got %b want 10", {empty, store_en});
        end
    endtask

    task automatic test_forwarding();
        int n;
        miss_hold = 1'b1;
        enq(1'b0, 32'h0000_2000, 32'h1122_3344, 1'b1);
        enq(1'b1, 32'h0000_2001, 32'h0000_00AA, 1'b1);
        enq(1'b0, 32'h0000_3008, 32'h5566_7788, 1'b1);
        enq(1'b0, 32'h0000_3008, 32'hCAFE_F00D, 1'b1);
        ld_addr = 32'h0000_2000; ld_isbyte = 1'b0; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict} !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_word_over_byte got %b want 01", {fwd_hit, fwd_conflict});
        end
        ld_addr = 32'h0000_2001; ld_isbyte = 1'b1; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict, fwd_data} !== {2'b10, 32'h0000_00AA}) begin
            miscompares++;
            $display("FAIL fwd_byte_same got %b/%h want 10/000000aa", {fwd_hit, fwd_conflict}, fwd_data);
        end
        ld_addr = 32'h0000_2002; ld_isbyte = 1'b1; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict} !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_byte_other got %b want 01", {fwd_hit, fwd_conflict});
        end
        ld_addr = 32'h0000_3008; ld_isbyte = 1'b0; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict, fwd_data} !== {2'b10, 32'hCAFE_F00D}) begin
            miscompares++;
            $display("FAIL fwd_youngest_wrap got %b/%h want 10/cafef00d", {fwd_hit, fwd_conflict}, fwd_data);
        end
        ld_addr = 32'h0000_300A; ld_isbyte = 1'b1; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict, fwd_data} !== {2'b10, 32'h0000_00FE}) begin
            miscompares++;
            $display("FAIL fwd_byte_of_word got %b/%h want 10/000000fe", {fwd_hit, fwd_conflict}, fwd_data);
        end
        ld_addr = 32'h0001_2000; ld_isbyte = 1'b0; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict} !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_tag_miss got %b want 00", {fwd_hit, fwd_conflict});
        end
        ld_addr = 32'h0000_1004; ld_isbyte = 1'b0; #1;
        vectors++;
        if ({fwd_hit, fwd_conflict} !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_drained_entry got %b want 00", {fwd_hit, fwd_conflict});
        end
        miss_hold = 1'b0;
        n = 0;
        while (empty !== 1'b1 && n < 80) begin tick(); n++; end
        tick();
        vectors++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL fwd_drain got empty=%b left=%0d want 1/0", empty, sb.size());
        end
    endtask

    task automatic test_miss_once();
        int n;
        int t0;
        int t1;
        int t2;
        int t3;
        miss_budget = 1;
        enq(1'b0, 32'h0000_4000, 32'h0BAD_F00D, 1'b1);
        t0 = cyc;
        n = 0;
        while (probe_en !== 1'b1 && n < 10) begin tick(); n++; end
        t1 = cyc;
        tick();
        n = 0;
        while (probe_en !== 1'b1 && n < 20) begin tick(); n++; end
        t2 = cyc;
        n = 0;
        while (store_en !== 1'b1 && n < 20) begin tick(); n++; end
        t3 = cyc;
        vectors++;
        if ((t1 - t0) != 1) begin
            miscompares++;
            $display("FAIL miss_first_probe got %0d want 1", t1 - t0);
        end
        vectors++;
        if ((t2 - t1) != 5) begin
            miscompares++;
            $display("FAIL miss_reprobe_gap got %0d want 5", t2 - t1);
        end
        vectors++;
        if ((t3 - t2) != 2) begin
            miscompares++;
            $display("FAIL miss_store_after_probe got %0d want 2", t3 - t2);
        end
        tick();
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL miss_empty got %b want 1", empty);
        end
    endtask

    task automatic test_enq_with_commit();
        int n;
        miss_hold = 1'b1;
        for (int i = 0; i < 3; i++) enq(1'b0, 32'h0000_6000 + 32'(i * 4), 32'h6000_0000 + 32'(i), 1'b1);
        miss_hold = 1'b0;
        n = 0;
        while (store_en !== 1'b1 && n < 20) begin tick(); n++; end
        vectors++;
        if (store_en !== 1'b1) begin
            miscompares++;
            $display("FAIL concurrent_wait got store_en=%b want 1", store_en);
        end
        enq(1'b0, 32'h0000_600C, 32'h6000_0003, 1'b1);
        vectors++;
        if ({full, empty} !== 2'b00) begin
            miscompares++;
            $display("FAIL concurrent_count got %b want 00", {full, empty});
        end
        enq(1'b0, 32'h0000_6010, 32'h6000_0004, 1'b1);
        vectors++;
        if (full !== 1'b1) begin
            miscompares++;
            $display("FAIL concurrent_then_full got %b want 1", full);
        end
        n = 0;
        while (empty !== 1'b1 && n < 100) begin tick(); n++; end
        tick();
        vectors++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL concurrent_drain got empty=%b left=%0d want 1/0", empty, sb.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        int stores;
        miss_hold = 1'b1;
        for (int i = 0; i < 3; i++) enq(1'b0, 32'h0000_5000 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b1);
        n = 0;
        while (probe_en !== 1'b1 && n < 20) begin tick(); n++; end
        tick();
        ld_addr = 32'h0000_5004; ld_isbyte = 1'b0; #1;
        vectors++;
        if (fwd_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset_fwd got %b want 1", fwd_hit);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        vectors++;
        if ({full, empty, probe_en, store_en, fwd_hit, fwd_conflict} !== 6'b010000) begin
            miscompares++;
            $display("FAIL midreset_flags got %b want 010000", {full, empty, probe_en, store_en, fwd_hit, fwd_conflict});
        end
        vectors++;
        if ({probe_addr, store_addr, fwd_data} !== 96'h0) begin
            miscompares++;
            $display("FAIL midreset_data got %h/%h/%h want zeros", probe_addr, store_addr, fwd_data);
        end
        miss_hold = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        stores = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (store_en === 1'b1) stores++;
        end
        vectors++;
        if (stores != 0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL postreset_quiet got stores=%0d empty=%b want 0/1", stores, empty);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        enq(1'b0, 32'h0000_7000, 32'h7777_0001, 1'b1);
        vectors++;
        if (empty !== 1'b0) begin
            miscompares++;
            $display("FAIL first_enq_after_reset got empty=%b want 0", empty);
        end
        n = 0;
        while (empty !== 1'b1 && n < 40) begin tick(); n++; end
        tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL postreset_drain got left=%0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_drop();
        test_single_store();
        test_forwarding();
        test_miss_once();
        test_enq_with_commit();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter RETRY_GAP, default 3, meaning idle cycles between a probe miss and the next probe.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have enq_en  in  1  committed store to buffer; enq_isbyte  in  1  byte store; enq_addr  in  pptr_t  physical address; enq_data  in  word_t  store data.
REQ-005 SHALL have full  out  1  no free entry; empty  out  1  no valid entry.
REQ-006 SHALL have probe_en  out  1  head lookup request to dcache; probe_addr  out  pptr_t  head address; probe_miss  in  1  dcache miss, valid exactly one cycle after probe_en.
REQ-007 SHALL have store_en  out  1  write head into dcache; store_isbyte  out  1; store_addr  out  pptr_t; store_data  out  word_t.
REQ-008 SHALL have ld_addr  in  pptr_t  load address; ld_isbyte  in  1; fwd_hit  out  1  forwarded data valid; fwd_data  out  word_t; fwd_conflict  out  1  load must replay.

Function
REQ-009 SHALL hold entries in a circular FIFO: head/tail pointers modulo DEPTH, count 0..DEPTH.
REQ-010 SHALL write enq_* into tail entry and advance tail on a clock edge with enq_en=1 and full=0.
REQ-011 SHALL drop enq_en while full=1; full is computed from the current count, with no same-cycle pop bypass.
REQ-012 SHALL drive full=(count==DEPTH) and empty=(count==0), both combinational from registered state.
REQ-013 SHALL run a drain FSM with states IDLE, PROBE, RESP, BACKOFF, COMMIT.
REQ-014 IDLE: if empty=0, go to PROBE; otherwise stay.
REQ-015 PROBE: drive probe_en=1 and probe_addr=head address for exactly one cycle; go to RESP.
REQ-016 RESP: sample probe_miss; 0 -> COMMIT; 1 -> BACKOFF with the gap counter loaded to RETRY_GAP.
REQ-017 BACKOFF: decrement the counter each cycle; at 0, go to PROBE.
REQ-018 COMMIT: drive store_en=1 and store_*=head entry for one cycle; pop head (advance head, decrement count); go to IDLE.
REQ-019 Drain latency SHALL be: first store_en 3 cycles after the entry becomes head with no miss; each probe miss adds RETRY_GAP+2 cycles.
REQ-020 Enqueue and COMMIT pop SHALL be allowed in the same cycle; count is unchanged and both pointers advance.
REQ-021 SHALL never modify the head entry while the FSM is outside IDLE; enqueue only writes the tail.
REQ-022 Forwarding SHALL be combinational: compare ld_addr tag and index, plus word offset offset[3:2], against all valid entries, including the head during COMMIT.
REQ-023 If the youngest matching entry is a word store, fwd_hit=1 and fwd_data=its data; for ld_isbyte=1, fwd_data={24'b0, the selected byte}.
REQ-024 If the youngest match is a byte store: same byte and ld_isbyte=1 -> fwd_hit=1; otherwise fwd_conflict=1 and fwd_hit=0.
REQ-025 With no match, fwd_hit=0 and fwd_conflict=0; fwd_hit and fwd_conflict SHALL never both be 1.
REQ-026 Entry youngest-ness SHALL be computed relative to tail, so that pointer wrap-around is correct.
REQ-027 probe_en, store_en, and FSM state SHALL be registered outputs/state, with no combinational path from probe_miss to store_en.

Reset
REQ-028 rst=0 SHALL asynchronously clear all entry valid bits, head=tail=0, count=0, FSM=IDLE, and gap counter=0.
REQ-029 During reset: full=0, empty=1, probe_en=0, store_en=0, fwd_hit=0, fwd_conflict=0; data outputs are 0.
REQ-030 Reset mid-drain SHALL discard all buffered stores, with no store_en after rst deasserts until a new enqueue.
REQ-031 The first enqueue SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-032 Single store, word 0xDEADBEEF at 0x00001004, probe_miss=0 -> probe_en at cycle+1, store_en at cycle+3 with store_addr=0x00001004, then empty=1.
REQ-033 Probe miss once, RETRY_GAP=3 -> second probe_en exactly 5 cycles after the first; store_en 2 cycles later.
REQ-034 Enqueue 4 stores with probe_miss held at 1 -> full=1; a 5th enq is dropped; releasing the miss drains all 4 in FIFO order, with pointers wrapping to 0.
REQ-035 Buffer word 0x11223344 then byte 0xAA at the same word, offset 1; word load -> fwd_conflict=1; byte load at offset 1 -> fwd_hit=1, fwd_data=0x000000AA.
REQ-036 Enqueue in the same cycle as COMMIT with count=DEPTH-1 -> count stays DEPTH-1, full stays 0.
REQ-037 Assert rst=0 during RESP with 3 entries buffered -> immediately empty=1 and probe_en=0, and no store_en afterwards.
